// File: rtl/xilly_mem8_responder_if.sv
// Bus bundle between xillybus_core and the mem_8 responder.
// The master modport is the core side and the slave modport is the responder side.
interface xilly_mem8_responder_if #(
  parameter int ADDR_W = 5
);

  // Read stream (responder to host)
  logic              user_r_mem_8_rden;
  logic [7:0]        user_r_mem_8_data;
  logic              user_r_mem_8_empty;
  logic              user_r_mem_8_eof;
  logic              user_r_mem_8_open;

  // Write stream (host to responder)
  logic              user_w_mem_8_wren;
  logic [7:0]        user_w_mem_8_data;
  logic              user_w_mem_8_full;
  logic              user_w_mem_8_open;

  // Seek port shared by both streams
  logic [ADDR_W-1:0] user_mem_8_addr;
  logic              user_mem_8_addr_update;

  modport master (
    output user_r_mem_8_rden,
    output user_r_mem_8_open,
    output user_w_mem_8_wren,
    output user_w_mem_8_data,
    output user_w_mem_8_open,
    output user_mem_8_addr,
    output user_mem_8_addr_update,
    input  user_r_mem_8_data,
    input  user_r_mem_8_empty,
    input  user_r_mem_8_eof,
    input  user_w_mem_8_full
  );

  modport slave (
    input  user_r_mem_8_rden,
    input  user_r_mem_8_open,
    input  user_w_mem_8_wren,
    input  user_w_mem_8_data,
    input  user_w_mem_8_open,
    input  user_mem_8_addr,
    input  user_mem_8_addr_update,
    output user_r_mem_8_data,
    output user_r_mem_8_empty,
    output user_r_mem_8_eof,
    output user_w_mem_8_full
  );

endinterface

// File: rtl/xilly_mem8_responder.sv
// Responder for the Xillybus seekable 8-bit stream pair (mem_8).
// Host reads and writes go to an on-chip byte RAM at one shared pointer
// that the host can seek. With EOF_AT_END=1 the pointer stops after the top
// byte and reports EOF, empty and full. With EOF_AT_END=0 it wraps to 0.
module xilly_mem8_responder #(
  parameter int ADDR_W     = 5,
  parameter int EOF_AT_END = 1
) (
  input  logic                          bus_clk,
  input  logic                          bus_rst,
  xilly_mem8_responder_if.slave         mem8
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // ACTIVE: the pointer addresses a valid byte.
  // PAST_END: the top byte has been consumed and requests are ignored until a seek.
  typedef enum logic {
    ACTIVE   = 1'b0,
    PAST_END = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        rd_data;
  logic              end_flag;

  logic [7:0]        ram [DEPTH];

  logic              rd_eff;
  logic              wr_eff;
  logic              seek;

  // A request counts only while its stream is open and the pointer is not past the end.
  // A seek in the same cycle overrides any request.
  always_comb begin
    seek   = mem8.user_mem_8_addr_update;
    rd_eff = mem8.user_r_mem_8_rden & mem8.user_r_mem_8_open & (state == ACTIVE) & ~seek;
    wr_eff = mem8.user_w_mem_8_wren & mem8.user_w_mem_8_open & (state == ACTIVE) & ~seek;
  end

  // Byte RAM write port. This block writes the contents only and never clears them.
  // NOTE: the RAM array has no reset branch on purpose. A reset loop over every entry
  // prevents block-RAM inference and forces the array into flip-flops.
  always_ff @(posedge bus_clk) begin
    if (!bus_rst && wr_eff) begin
      ram[ptr] <= mem8.user_w_mem_8_data;
    end
  end

  // Pointer, end state, registered read data and the registered flag output.
  // The read samples ram[ptr] in the same edge as the write, so a read and a write
  // in the same cycle return the old byte.
  // NOTE: sequential state uses non-blocking assignments only. Every register then
  // samples values from before the edge. This is what produces read-before-write here.
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state    <= ACTIVE;
      ptr      <= '0;
      rd_data  <= 8'h00;
      end_flag <= 1'b0;
    end else if (seek) begin
      state    <= ACTIVE;
      ptr      <= mem8.user_mem_8_addr;
      end_flag <= 1'b0;
    end else begin
      if (rd_eff) begin
        rd_data <= ram[ptr];
      end
      if (rd_eff || wr_eff) begin
        if (ptr != LAST_ADDR) begin
          ptr <= ptr + 1'b1;
        end else if (EOF_AT_END != 0) begin
          state    <= PAST_END;
          end_flag <= 1'b1;
        end else begin
          ptr <= '0;
        end
      end
    end
  end

  // The three end-of-memory indications are the same registered condition.
  always_comb begin
    mem8.user_r_mem_8_data  = rd_data;
    mem8.user_r_mem_8_empty = end_flag;
    mem8.user_r_mem_8_eof   = end_flag;
    mem8.user_w_mem_8_full  = end_flag;
  end

endmodule

// File: tb/tb_xilly_mem8_responder.sv
// Self-checking bench for xilly_mem8_responder. It drives the same stimulus into
// two instances: one with EOF_AT_END=1 and one with EOF_AT_END=0. Each instance
// is checked every cycle against its own behavioural model. There are also
// directed scenarios with literal expected bytes.
module tb_xilly_mem8_responder;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic bus_clk = 1'b0;
  logic bus_rst;

  always #5 bus_clk = ~bus_clk;

  // Shared stimulus for both instances
  logic              in_rd, in_ro, in_wr, in_wo, in_up;
  logic [7:0]        in_wd;
  logic [ADDR_W-1:0] in_a;

  xilly_mem8_responder_if #(.ADDR_W(ADDR_W)) bus_wrap ();
  xilly_mem8_responder_if #(.ADDR_W(ADDR_W)) bus_eof ();

  assign bus_wrap.user_r_mem_8_rden      = in_rd;
  assign bus_wrap.user_r_mem_8_open      = in_ro;
  assign bus_wrap.user_w_mem_8_wren      = in_wr;
  assign bus_wrap.user_w_mem_8_data      = in_wd;
  assign bus_wrap.user_w_mem_8_open      = in_wo;
  assign bus_wrap.user_mem_8_addr        = in_a;
  assign bus_wrap.user_mem_8_addr_update = in_up;

  assign bus_eof.user_r_mem_8_rden       = in_rd;
  assign bus_eof.user_r_mem_8_open       = in_ro;
  assign bus_eof.user_w_mem_8_wren       = in_wr;
  assign bus_eof.user_w_mem_8_data       = in_wd;
  assign bus_eof.user_w_mem_8_open       = in_wo;
  assign bus_eof.user_mem_8_addr         = in_a;
  assign bus_eof.user_mem_8_addr_update  = in_up;

  xilly_mem8_responder #(.ADDR_W(ADDR_W), .EOF_AT_END(0)) dut_wrap (
    .bus_clk (bus_clk),
    .bus_rst (bus_rst),
    .mem8    (bus_wrap.slave)
  );

  xilly_mem8_responder #(.ADDR_W(ADDR_W), .EOF_AT_END(1)) dut_eof (
    .bus_clk (bus_clk),
    .bus_rst (bus_rst),
    .mem8    (bus_eof.slave)
  );

  // Reference model state. Index 0 is the wrap instance and index 1 is the EOF instance.
  logic [7:0] m_mem  [2][DEPTH];
  int         m_ptr  [2];
  bit         m_end  [2];
  logic [7:0] m_data [2];
  logic [7:0] init_bytes [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of the behaviour as described: a read takes the old byte, a write
  // stores the new byte, and the pointer then moves one place (wrap, or stop at the end).
  task automatic model_step(input int e);
    bit rd, wr;
    if (bus_rst) begin
      m_ptr[e]  = 0;
      m_end[e]  = 0;
      m_data[e] = 8'h00;
    end else if (in_up) begin
      m_ptr[e] = int'(in_a);
      m_end[e] = 0;
    end else begin
      rd = in_rd && in_ro && !m_end[e];
      wr = in_wr && in_wo && !m_end[e];
      if (rd) m_data[e] = m_mem[e][m_ptr[e]];
      if (wr) m_mem[e][m_ptr[e]] = in_wd;
      if (rd || wr) begin
        if (m_ptr[e] < DEPTH - 1) m_ptr[e] = m_ptr[e] + 1;
        else if (e == 1)          m_end[e] = 1;
        else                      m_ptr[e] = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check("wrap_data",  {24'd0, bus_wrap.user_r_mem_8_data}, {24'd0, m_data[0]});
    check("wrap_empty", {31'd0, bus_wrap.user_r_mem_8_empty}, 32'd0);
    check("wrap_eof",   {31'd0, bus_wrap.user_r_mem_8_eof},   32'd0);
    check("wrap_full",  {31'd0, bus_wrap.user_w_mem_8_full},  32'd0);
    check("eof_data",   {24'd0, bus_eof.user_r_mem_8_data},  {24'd0, m_data[1]});
    check("eof_empty",  {31'd0, bus_eof.user_r_mem_8_empty}, {31'd0, m_end[1]});
    check("eof_eof",    {31'd0, bus_eof.user_r_mem_8_eof},   {31'd0, m_end[1]});
    check("eof_full",   {31'd0, bus_eof.user_w_mem_8_full},  {31'd0, m_end[1]});
  endtask

  // Drive one cycle of stimulus on the falling edge. Advance the models at the rising
  // edge and compare just after it.
  task automatic step(input logic rd, input logic ro, input logic wr, input logic wo,
                      input logic [7:0] wd, input logic [ADDR_W-1:0] a,
                      input logic up, input logic rs);
    in_rd = rd; in_ro = ro; in_wr = wr; in_wo = wo;
    in_wd = wd; in_a = a; in_up = up; bus_rst = rs;
    @(posedge bus_clk);
    model_step(0);
    model_step(1);
    #1;
    check_outputs();
    @(negedge bus_clk);
  endtask

  task automatic do_idle();                     step(0, 1, 0, 1, 8'h00, '0, 0, 0); endtask
  task automatic do_rst();                      step(0, 1, 0, 1, 8'h00, '0, 0, 1); endtask
  task automatic do_seek(input logic [4:0] a);  step(0, 1, 0, 1, 8'h00, a,  1, 0); endtask
  task automatic do_rd();                       step(1, 1, 0, 1, 8'h00, '0, 0, 0); endtask
  task automatic do_wr(input logic [7:0] d);    step(0, 1, 1, 1, d,     '0, 0, 0); endtask

  initial begin
    in_rd = 0; in_ro = 1; in_wr = 0; in_wo = 1; in_wd = '0; in_a = '0; in_up = 0;
    bus_rst = 1;
    @(negedge bus_clk);

    // Reset state
    do_rst();
    check("rst_data", {24'd0, bus_eof.user_r_mem_8_data}, 32'h00);
    check("rst_flag", {31'd0, bus_eof.user_r_mem_8_empty}, 32'd0);

    // Fill every RAM byte with known content.
    do_seek(5'd0);
    for (int i = 0; i < DEPTH; i++) begin
      init_bytes[i] = 8'($urandom);
      do_wr(init_bytes[i]);
    end
    check("fill_end_eof", {31'd0, bus_eof.user_r_mem_8_eof}, 32'd1);

    // Seek 3 and write three bytes. Then seek 3 again and read them back.
    do_rst();
    do_seek(5'd3);
    do_wr(8'hA1); do_wr(8'hB2); do_wr(8'hC3);
    do_seek(5'd3);
    do_rd(); check("s2_byte0", {24'd0, bus_eof.user_r_mem_8_data}, 32'hA1);
    do_rd(); check("s2_byte1", {24'd0, bus_eof.user_r_mem_8_data}, 32'hB2);
    do_rd(); check("s2_byte2", {24'd0, bus_eof.user_r_mem_8_data}, 32'hC3);
    check("s2_empty", {31'd0, bus_eof.user_r_mem_8_empty}, 32'd0);
    do_rd(); check("s2_ptr6", {24'd0, bus_eof.user_r_mem_8_data}, {24'd0, init_bytes[6]});

    // Read the top two bytes. EOF takes effect after the last one, and later reads are ignored.
    do_seek(5'd30);
    do_rd(); check("s3_b30", {24'd0, bus_eof.user_r_mem_8_data}, {24'd0, init_bytes[30]});
    do_rd(); check("s3_b31", {24'd0, bus_eof.user_r_mem_8_data}, {24'd0, init_bytes[31]});
    check("s3_eof_set",  {31'd0, bus_eof.user_r_mem_8_eof},   32'd1);
    check("s3_full_set", {31'd0, bus_eof.user_w_mem_8_full},  32'd1);
    check("s3_wrap_no",  {31'd0, bus_wrap.user_r_mem_8_empty}, 32'd0);
    do_rd(); check("s3_hold", {24'd0, bus_eof.user_r_mem_8_data}, {24'd0, init_bytes[31]});
    do_seek(5'd0);
    check("s3_clear", {31'd0, bus_eof.user_r_mem_8_empty}, 32'd0);
    do_rd(); check("s3_resume", {24'd0, bus_eof.user_r_mem_8_data}, {24'd0, init_bytes[0]});

    // Wrap instance: writes at 31 continue at 0.
    do_seek(5'd31);
    do_wr(8'h5A); do_wr(8'h6B);
    do_rd(); check("s4_ptr1", {24'd0, bus_wrap.user_r_mem_8_data}, {24'd0, init_bytes[1]});
    do_seek(5'd31);
    do_rd(); check("s4_m31", {24'd0, bus_wrap.user_r_mem_8_data}, 32'h5A);
    do_rd(); check("s4_m0",  {24'd0, bus_wrap.user_r_mem_8_data}, 32'h6B);

    // A read and a write in the same cycle return the old byte.
    // A seek drops any request in its cycle.
    do_seek(5'd7);
    do_wr(8'h11);
    do_seek(5'd7);
    step(1, 1, 1, 1, 8'h99, '0, 0, 0);
    check("s5_rbw", {24'd0, bus_eof.user_r_mem_8_data}, 32'h11);
    do_rd(); check("s5_ptr8", {24'd0, bus_eof.user_r_mem_8_data}, {24'd0, init_bytes[8]});
    do_seek(5'd7);
    do_rd(); check("s5_new", {24'd0, bus_eof.user_r_mem_8_data}, 32'h99);
    step(1, 1, 1, 1, 8'h77, 5'd2, 1, 0);
    check("s5_seek_hold", {24'd0, bus_eof.user_r_mem_8_data}, 32'h99);
    do_rd(); check("s5_nowrite", {24'd0, bus_eof.user_r_mem_8_data}, {24'd0, init_bytes[2]});

    // Reset in the middle of a burst, then reads while the read stream is closed.
    do_seek(5'd31);
    do_rd();
    step(1, 1, 0, 1, 8'h00, '0, 0, 1);
    check("s6_rst_data", {24'd0, bus_eof.user_r_mem_8_data}, 32'h00);
    check("s6_rst_flag", {31'd0, bus_eof.user_r_mem_8_eof}, 32'd0);
    step(1, 0, 0, 1, 8'h00, '0, 0, 0);
    step(1, 0, 0, 1, 8'h00, '0, 0, 0);
    check("s6_closed", {24'd0, bus_eof.user_r_mem_8_data}, 32'h00);
    do_rd(); check("s6_reopen", {24'd0, bus_wrap.user_r_mem_8_data}, 32'h6B);

    // Random traffic checked against the models
    for (int c = 0; c < 3000; c++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0),
           8'($urandom), 5'($urandom),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 199) == 0));
    end
    do_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
